// File: rtl/mux_scan_ctrl.sv
// Scan/select controller for a downstream 4:1 mux: auto-scan with per-channel dwell, or manual select.
// Optional macro SCAN_SKIP_EN adds ch_mask so auto-scan skips disabled channels.
module mux_scan_ctrl #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic [1:0]         man_sel,
    input  logic [DWELL_W-1:0] dwell,
`ifdef SCAN_SKIP_EN
    input  logic [3:0]         ch_mask,
`endif
    output logic               Sel1,
    output logic               Sel2,
    output logic [1:0]         ch,
    output logic               strobe,
    output logic               busy,
    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        MANUAL = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [1:0]         ch_q, ch_nxt;
    logic [DWELL_W-1:0] cnt, cnt_nxt;
    logic               strobe_q, strobe_nxt;
    logic [3:0]         scan_mask;
    logic [1:0]         adv_ch;
    logic               adv_ok;
    logic [1:0]         cand;

`ifdef SCAN_SKIP_EN
    assign scan_mask = ch_mask;
`else
    assign scan_mask = 4'hF;
`endif

    // Nearest enabled channel after ch_q in cyclic order; k=4 lands back on ch_q itself.
    always_comb begin
        adv_ch = ch_q;
        adv_ok = 1'b0;
        cand   = ch_q;
        for (int k = 4; k >= 1; k--) begin
            cand = ch_q + 2'(k);
            if (scan_mask[cand]) begin
                adv_ch = cand;
                adv_ok = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        ch_nxt     = ch_q;
        cnt_nxt    = cnt;
        strobe_nxt = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
        end else if (mode) begin
            state_nxt  = MANUAL;
            ch_nxt     = man_sel;
            strobe_nxt = (man_sel != ch_q);
        end else begin
            case (state)
                SCAN: begin
                    if (cnt != '0) begin
                        cnt_nxt = cnt - 1'b1;
                    end else begin
                        // With no enabled channel, hold ch and stay silent.
                        cnt_nxt    = dwell;
                        ch_nxt     = adv_ch;
                        strobe_nxt = adv_ok;
                    end
                end
                default: begin
                    state_nxt  = SCAN;
                    cnt_nxt    = dwell;
                    strobe_nxt = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ch_q     <= 2'd0;
            cnt      <= '0;
            strobe_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            ch_q     <= ch_nxt;
            cnt      <= cnt_nxt;
            strobe_q <= strobe_nxt;
        end
    end

    assign ch        = ch_q;
    assign Sel1      = ch_q[0];
    assign Sel2      = ch_q[1];
    assign strobe    = strobe_q;
    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule
